// File: rtl/csr_addrs.sv
// Machine-mode CSR addresses shared by every block that decodes the CSR port.
package csr_addrs;

    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;

endpackage

// File: rtl/trap_causes.sv
// Synchronous exception cause codes raised by the ifetch and exec stages.
package trap_causes;

    localparam int unsigned EXC_INSTR_MISALIGNED = 0;
    localparam int unsigned EXC_INSTR_FAULT      = 1;
    localparam int unsigned EXC_ILLEGAL_INSTR    = 2;
    localparam int unsigned EXC_BREAKPOINT       = 3;
    localparam int unsigned EXC_LOAD_MISALIGNED  = 4;
    localparam int unsigned EXC_LOAD_FAULT       = 5;
    localparam int unsigned EXC_STORE_MISALIGNED = 6;
    localparam int unsigned EXC_STORE_FAULT      = 7;
    localparam int unsigned EXC_ECALL_M          = 11;

endpackage

// File: rtl/trap_csr_file.sv
// The five trap CSRs: read mux, CSR-port writes and the trap-entry capture.
// The caller guarantees i_wen and i_trap_we are never both high.
module trap_csr_file
    import csr_addrs::*;
#(
    parameter int             XW          = 32,
    parameter logic [XW-1:0]  RESET_MTVEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       i_addr,
    input  logic              i_wen,
    input  logic [XW-1:0]     i_wdata,
    input  logic              i_trap_we,
    input  logic [XW-1:0]     i_trap_pc,
    input  logic [XW-1:0]     i_trap_cause,
    input  logic [XW-1:0]     i_trap_tval,
    output logic [XW-1:0]     o_rdata,
    output logic              o_hit,
    output logic [XW-1:0]     o_mtvec,
    output logic [XW-1:0]     o_mepc
);

    logic [XW-1:0] r_mtvec;
    logic [XW-1:0] r_mscratch;
    logic [XW-1:0] r_mepc;
    logic [XW-1:0] r_mcause;
    logic [XW-1:0] r_mtval;

    // NOTE: these are architectural registers with defined reset values, so
    // every one is reset; a RAM-style storage array would be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtvec    <= RESET_MTVEC;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else if (i_trap_we) begin
            r_mepc   <= i_trap_pc;
            r_mcause <= i_trap_cause;
            r_mtval  <= i_trap_tval;
        end else if (i_wen) begin
            case (i_addr)
                CSR_MTVEC:    r_mtvec    <= i_wdata;
                CSR_MSCRATCH: r_mscratch <= i_wdata;
                CSR_MEPC:     r_mepc     <= {i_wdata[XW-1:2], 2'b00};
                CSR_MCAUSE:   r_mcause   <= i_wdata;
                CSR_MTVAL:    r_mtval    <= i_wdata;
                default:      ;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        o_rdata = '0;
        o_hit   = 1'b1;
        case (i_addr)
            CSR_MTVEC:    o_rdata = r_mtvec;
            CSR_MSCRATCH: o_rdata = r_mscratch;
            CSR_MEPC:     o_rdata = r_mepc;
            CSR_MCAUSE:   o_rdata = r_mcause;
            CSR_MTVAL:    o_rdata = r_mtval;
            default:      o_hit   = 1'b0;
        endcase
    end

    assign o_mtvec = r_mtvec;
    assign o_mepc  = r_mepc;

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap responder: captures exceptions, executes MRET, redirects the PC.
// Define TRAP_VECTORED_EN to enable base + 4*cause targets for mtvec mode 1.
`ifndef XLEN
`define XLEN 32
`endif

module trap_unit #(
    parameter int             XW          = `XLEN,
    parameter logic [XW-1:0]  RESET_MTVEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_exc_valid,
    input  logic [XW-1:0]     if_exc_pc,
    input  logic [XW-1:0]     if_exc_tval,
    input  logic [XW-1:0]     if_exc_cause,
    input  logic              ex_exc_valid,
    input  logic [XW-1:0]     ex_exc_pc,
    input  logic [XW-1:0]     ex_exc_tval,
    input  logic [XW-1:0]     ex_exc_cause,
    input  logic              mret_valid,
    input  logic [11:0]       csr_addr,
    input  logic              csr_wen,
    input  logic [XW-1:0]     csr_wdata,
    output logic [XW-1:0]     csr_rdata,
    output logic              csr_hit,
    output logic              redirect_valid,
    output logic [XW-1:0]     redirect_pc,
    input  logic              redirect_ready,
    output logic              busy
);

    typedef enum logic {
        S_IDLE,
        S_REDIRECT
    } state_e;

    state_e        r_state;
    state_e        w_next_state;
    logic [XW-1:0] r_redirect_pc;

    logic          w_idle;
    logic          w_take_trap;
    logic          w_take_mret;
    logic          w_csr_we;
    logic [XW-1:0] w_trap_pc;
    logic [XW-1:0] w_trap_cause;
    logic [XW-1:0] w_trap_tval;
    logic [XW-1:0] w_mtvec;
    logic [XW-1:0] w_mepc;
    logic [XW-1:0] w_base;
    logic [XW-1:0] w_trap_target;

    assign w_idle      = (r_state == S_IDLE);
    assign w_take_trap = w_idle && (ex_exc_valid || if_exc_valid);
    assign w_take_mret = w_idle && mret_valid && !(ex_exc_valid || if_exc_valid);
    // The faulting instruction never retires, so its CSR write is discarded.
    assign w_csr_we    = csr_wen && w_idle && !(ex_exc_valid || if_exc_valid);

    // Exec holds the older instruction, so it wins over ifetch.
    assign w_trap_pc    = ex_exc_valid ? ex_exc_pc    : if_exc_pc;
    assign w_trap_cause = ex_exc_valid ? ex_exc_cause : if_exc_cause;
    assign w_trap_tval  = ex_exc_valid ? ex_exc_tval  : if_exc_tval;

    assign w_base = w_mtvec & ~{{(XW-2){1'b0}}, 2'b11};

`ifdef TRAP_VECTORED_EN
    assign w_trap_target = (w_mtvec[1:0] == 2'b01 && w_trap_cause[XW-1])
                         ? w_base + {w_trap_cause[XW-3:0], 2'b00}
                         : w_base;
`else
    assign w_trap_target = w_base;
`endif

    trap_csr_file #(
        .XW          (XW),
        .RESET_MTVEC (RESET_MTVEC)
    ) u_csr_file (
        .clk          (clk),
        .rst          (rst),
        .i_addr       (csr_addr),
        .i_wen        (w_csr_we),
        .i_wdata      (csr_wdata),
        .i_trap_we    (w_take_trap),
        .i_trap_pc    (w_trap_pc),
        .i_trap_cause (w_trap_cause),
        .i_trap_tval  (w_trap_tval),
        .o_rdata      (csr_rdata),
        .o_hit        (csr_hit),
        .o_mtvec      (w_mtvec),
        .o_mepc       (w_mepc)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (w_take_trap || w_take_mret) w_next_state = S_REDIRECT;
            S_REDIRECT: if (redirect_ready)             w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        redirect_valid = (r_state == S_REDIRECT);
        busy           = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_redirect_pc <= '0;
        else if (w_take_trap) r_redirect_pc <= w_trap_target;
        else if (w_take_mret) r_redirect_pc <= w_mepc;
    end

    assign redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: directed scenarios plus randomized traffic
// checked against a transaction-level model of the trap CSRs and redirect.
module tb_trap_unit;
    import trap_causes::*;
    import csr_addrs::*;

    localparam int XW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_exc_valid, ex_exc_valid, mret_valid, csr_wen, redirect_ready;
    logic [XW-1:0] if_exc_pc, if_exc_tval, if_exc_cause;
    logic [XW-1:0] ex_exc_pc, ex_exc_tval, ex_exc_cause;
    logic [11:0]   csr_addr;
    logic [XW-1:0] csr_wdata, csr_rdata, redirect_pc;
    logic          csr_hit, redirect_valid, busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [XW-1:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_rpc;
    bit            m_busy;

    trap_unit #(.XW(XW), .RESET_MTVEC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .if_exc_valid(if_exc_valid), .if_exc_pc(if_exc_pc),
        .if_exc_tval(if_exc_tval), .if_exc_cause(if_exc_cause),
        .ex_exc_valid(ex_exc_valid), .ex_exc_pc(ex_exc_pc),
        .ex_exc_tval(ex_exc_tval), .ex_exc_cause(ex_exc_cause),
        .mret_valid(mret_valid), .csr_addr(csr_addr), .csr_wen(csr_wen),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_hit(csr_hit),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    task automatic model_reset();
        m_mtvec = '0; m_mscratch = '0; m_mepc = '0;
        m_mcause = '0; m_mtval = '0; m_rpc = '0; m_busy = 0;
    endtask

    function automatic logic [XW-1:0] model_target(input logic [XW-1:0] cause);
        logic [XW-1:0] base;
        base = (m_mtvec / 4) * 4;
`ifdef TRAP_VECTORED_EN
        if (m_mtvec % 4 == 1 && cause >= 32'h8000_0000)
            return base + 4 * cause;
`endif
        return base;
    endfunction

    function automatic logic [XW-1:0] model_read(input logic [11:0] a, output bit hit);
        hit = 1;
        case (a)
            CSR_MTVEC:    return m_mtvec;
            CSR_MSCRATCH: return m_mscratch;
            CSR_MEPC:     return m_mepc;
            CSR_MCAUSE:   return m_mcause;
            CSR_MTVAL:    return m_mtval;
            default: begin hit = 0; return '0; end
        endcase
    endfunction

    // Applies one clock of the architectural rules to the currently driven inputs.
    task automatic model_cycle();
        bit exc;
        exc = ex_exc_valid || if_exc_valid;
        if (!m_busy) begin
            if (exc) begin
                m_mepc   = ex_exc_valid ? ex_exc_pc    : if_exc_pc;
                m_mcause = ex_exc_valid ? ex_exc_cause : if_exc_cause;
                m_mtval  = ex_exc_valid ? ex_exc_tval  : if_exc_tval;
                m_rpc    = model_target(m_mcause);
                m_busy   = 1;
            end else begin
                if (mret_valid) begin
                    m_rpc  = m_mepc;
                    m_busy = 1;
                end
                if (csr_wen) begin
                    case (csr_addr)
                        CSR_MTVEC:    m_mtvec    = csr_wdata;
                        CSR_MSCRATCH: m_mscratch = csr_wdata;
                        CSR_MEPC:     m_mepc     = (csr_wdata / 4) * 4;
                        CSR_MCAUSE:   m_mcause   = csr_wdata;
                        CSR_MTVAL:    m_mtval    = csr_wdata;
                        default:      ;
                    endcase
                end
            end
        end else if (redirect_ready) begin
            m_busy = 0;
        end
    endtask

    // ---------------- drive helpers ----------------
    task automatic clear_inputs();
        if_exc_valid = 0; if_exc_pc = '0; if_exc_tval = '0; if_exc_cause = '0;
        ex_exc_valid = 0; ex_exc_pc = '0; ex_exc_tval = '0; ex_exc_cause = '0;
        mret_valid = 0; csr_addr = 12'h000; csr_wen = 0; csr_wdata = '0;
        redirect_ready = 0;
    endtask

    task automatic cyc();
        model_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic rd(input logic [11:0] a, output logic [XW-1:0] d);
        csr_addr = a;
        csr_wen  = 0;
        #1;
        d = csr_rdata;
    endtask

    task automatic wr(input logic [11:0] a, input logic [XW-1:0] d);
        csr_addr = a; csr_wen = 1; csr_wdata = d;
        cyc();
    endtask

    task automatic ex_trap(input logic [XW-1:0] pc, input logic [XW-1:0] tval,
                           input logic [XW-1:0] cause);
        ex_exc_valid = 1; ex_exc_pc = pc; ex_exc_tval = tval; ex_exc_cause = cause;
        cyc();
    endtask

    task automatic accept_redirect();
        redirect_ready = 1;
        cyc();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [XW-1:0] d;
        logic [11:0] addrs [5];
        addrs = '{CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL};
        rst = 1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_valid: got %b want 0", redirect_valid); end
        n_tests++; if (redirect_pc !== '0) begin n_fail++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        foreach (addrs[i]) begin
            rd(addrs[i], d);
            n_tests++; if (d !== '0 || csr_hit !== 1'b1) begin n_fail++; $display("FAIL reset_csr_%h: got %h hit %b want 0 hit 1", addrs[i], d, csr_hit); end
        end
        rd(12'h300, d);
        n_tests++; if (d !== '0 || csr_hit !== 1'b0) begin n_fail++; $display("FAIL unowned_csr: got %h hit %b want 0 hit 0", d, csr_hit); end
        @(posedge clk);
        #1;
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_basic_trap();
        logic [XW-1:0] d;
        wr(CSR_MTVEC, 32'h32);
        ex_trap(32'h14, 32'hF11FD073, 32'(EXC_ILLEGAL_INSTR));
        n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL trap_redirect_valid: got %b want 1", redirect_valid); end
        n_tests++; if (redirect_pc !== 32'h30) begin n_fail++; $display("FAIL trap_redirect_pc: got %h want 30", redirect_pc); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL trap_busy: got %b want 1", busy); end
        rd(CSR_MEPC, d);
        n_tests++; if (d !== 32'h14) begin n_fail++; $display("FAIL trap_mepc: got %h want 14", d); end
        rd(CSR_MCAUSE, d);
        n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL trap_mcause: got %h want 2", d); end
        rd(CSR_MTVAL, d);
        n_tests++; if (d !== 32'hF11FD073) begin n_fail++; $display("FAIL trap_mtval: got %h want F11FD073", d); end
        accept_redirect();
        n_tests++; if (redirect_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL trap_release: got valid %b busy %b want 0 0", redirect_valid, busy); end
    endtask

    task automatic test_priority();
        logic [XW-1:0] d;
        if_exc_valid = 1; if_exc_pc = 32'h4; if_exc_tval = 32'h1111; if_exc_cause = 32'(EXC_INSTR_FAULT);
        ex_exc_valid = 1; ex_exc_pc = 32'h8; ex_exc_tval = 32'h2222; ex_exc_cause = 32'(EXC_ECALL_M);
        cyc();
        rd(CSR_MEPC, d);
        n_tests++; if (d !== 32'h8) begin n_fail++; $display("FAIL prio_mepc: got %h want 8", d); end
        rd(CSR_MCAUSE, d);
        n_tests++; if (d !== 32'd11) begin n_fail++; $display("FAIL prio_mcause: got %h want b", d); end
        accept_redirect();
        repeat (3) cyc();
        rd(CSR_MEPC, d);
        n_tests++; if (d !== 32'h8 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL prio_if_not_replayed: got mepc %h valid %b want 8 0", d, redirect_valid); end
    endtask

    task automatic test_stall_and_mret();
        logic [XW-1:0] d, held_pc, cause_before;
        ex_trap(32'h40, 32'h0, 32'(EXC_BREAKPOINT));
        held_pc = redirect_pc;
        n_tests++; if (held_pc !== 32'h30) begin n_fail++; $display("FAIL stall_target: got %h want 30", held_pc); end
        for (int i = 0; i < 5; i++) begin
            ex_exc_valid = 1; ex_exc_pc = 32'h200 + 32'(i) * 4; ex_exc_cause = 32'(EXC_LOAD_FAULT);
            if_exc_valid = i[0]; if_exc_pc = 32'h300;
            mret_valid = 1;
            csr_addr = CSR_MSCRATCH; csr_wen = 1; csr_wdata = 32'h55;
            cyc();
            n_tests++; if (redirect_valid !== 1'b1 || busy !== 1'b1 || redirect_pc !== held_pc) begin
                n_fail++; $display("FAIL stall_hold_%0d: got valid %b busy %b pc %h want 1 1 %h", i, redirect_valid, busy, redirect_pc, held_pc); end
            rd(CSR_MEPC, d);
            n_tests++; if (d !== 32'h40) begin n_fail++; $display("FAIL stall_mepc_%0d: got %h want 40", i, d); end
        end
        rd(CSR_MSCRATCH, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL stall_csr_drop: got %h want 0", d); end
        accept_redirect();
        n_tests++; if (redirect_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stall_release: got valid %b busy %b want 0 0", redirect_valid, busy); end

        // ready with nothing pending must not shortcut a trap raised the same cycle
        redirect_ready = 1; ex_exc_valid = 1; ex_exc_pc = 32'h44; ex_exc_cause = 32'(EXC_ILLEGAL_INSTR);
        cyc();
        n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL ready_when_idle: got valid %b want 1", redirect_valid); end
        accept_redirect();

        wr(CSR_MEPC, 32'h103);
        rd(CSR_MEPC, d);
        n_tests++; if (d !== 32'h100) begin n_fail++; $display("FAIL mepc_mask: got %h want 100", d); end
        rd(CSR_MCAUSE, cause_before);
        mret_valid = 1;
        cyc();
        n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin n_fail++; $display("FAIL mret_redirect: got valid %b pc %h want 1 100", redirect_valid, redirect_pc); end
        rd(CSR_MCAUSE, d);
        n_tests++; if (d !== 32'(EXC_ILLEGAL_INSTR) || d !== cause_before) begin n_fail++; $display("FAIL mret_mcause: got %h want 2", d); end
        accept_redirect();

        // exception and MRET together: MRET is dropped
        mret_valid = 1; if_exc_valid = 1; if_exc_pc = 32'h88; if_exc_cause = 32'(EXC_INSTR_MISALIGNED);
        cyc();
        rd(CSR_MEPC, d);
        n_tests++; if (redirect_pc !== 32'h30 || d !== 32'h88) begin n_fail++; $display("FAIL exc_over_mret: got pc %h mepc %h want 30 88", redirect_pc, d); end
        accept_redirect();
    endtask

    task automatic test_csr_drop();
        logic [XW-1:0] d;
        csr_addr = CSR_MSCRATCH; csr_wen = 1; csr_wdata = 32'hAA;
        ex_exc_valid = 1; ex_exc_pc = 32'h60; ex_exc_cause = 32'(EXC_STORE_FAULT);
        cyc();
        rd(CSR_MSCRATCH, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL csr_drop_on_trap: got %h want 0", d); end
        accept_redirect();
        wr(CSR_MSCRATCH, 32'hAA);
        rd(CSR_MSCRATCH, d);
        n_tests++; if (d !== 32'hAA) begin n_fail++; $display("FAIL csr_retry: got %h want aa", d); end
        csr_addr = CSR_MSCRATCH; csr_wen = 1; csr_wdata = 32'hBB;
        #1;
        n_tests++; if (csr_rdata !== 32'hAA) begin n_fail++; $display("FAIL read_during_write: got %h want aa", csr_rdata); end
        cyc();
        rd(CSR_MSCRATCH, d);
        n_tests++; if (d !== 32'hBB) begin n_fail++; $display("FAIL write_lands: got %h want bb", d); end
    endtask

    task automatic test_vectored();
        logic [XW-1:0] d, want;
        wr(CSR_MTVEC, 32'h101);
        rd(CSR_MTVEC, d);
        n_tests++; if (d !== 32'h101) begin n_fail++; $display("FAIL mtvec_readback: got %h want 101", d); end
        ex_trap(32'h20, 32'h0, 32'h8000_0003);
`ifdef TRAP_VECTORED_EN
        want = 32'h10C;
`else
        want = 32'h100;
`endif
        n_tests++; if (redirect_pc !== want) begin n_fail++; $display("FAIL vectored_msb_cause: got %h want %h", redirect_pc, want); end
        accept_redirect();
        ex_trap(32'h24, 32'h0, 32'(EXC_ILLEGAL_INSTR));
        n_tests++; if (redirect_pc !== 32'h100) begin n_fail++; $display("FAIL vectored_exception_base: got %h want 100", redirect_pc); end
        accept_redirect();
    endtask

    task automatic test_reset_mid_redirect();
        logic [XW-1:0] d;
        ex_trap(32'h70, 32'h5, 32'(EXC_LOAD_MISALIGNED));
        #2;
        rst = 1;
        #1;
        model_reset();
        n_tests++; if (redirect_valid !== 1'b0 || busy !== 1'b0 || redirect_pc !== '0) begin
            n_fail++; $display("FAIL async_reset: got valid %b busy %b pc %h want 0 0 0", redirect_valid, busy, redirect_pc); end
        rd(CSR_MEPC, d);
        n_tests++; if (d !== '0) begin n_fail++; $display("FAIL async_reset_mepc: got %h want 0", d); end
        @(posedge clk);
        #1;
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_random();
        logic [11:0] addrs [6];
        logic [XW-1:0] exp_d;
        bit exp_hit;
        addrs = '{CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, 12'h344};
        for (int n = 0; n < 400; n++) begin
            ex_exc_valid = ($urandom_range(0, 4) == 0);
            ex_exc_pc = $urandom() & ~32'h3; ex_exc_tval = $urandom();
            ex_exc_cause = ($urandom_range(0, 3) == 0) ? (32'h8000_0000 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 11));
            if_exc_valid = ($urandom_range(0, 4) == 0);
            if_exc_pc = $urandom() & ~32'h3; if_exc_tval = $urandom();
            if_exc_cause = ($urandom_range(0, 3) == 0) ? (32'h8000_0000 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 11));
            mret_valid = ($urandom_range(0, 4) == 0);
            redirect_ready = $urandom_range(0, 1) == 1;
            csr_addr = addrs[$urandom_range(0, 5)];
            csr_wen = ($urandom_range(0, 2) == 0);
            csr_wdata = ($urandom_range(0, 1) == 1) ? (($urandom() & ~32'h3) | 32'h1) : $urandom();
            #1;
            exp_d = model_read(csr_addr, exp_hit);
            n_tests++; if (csr_rdata !== exp_d || csr_hit !== exp_hit) begin
                n_fail++; $display("FAIL rand_read_%0d addr %h: got %h hit %b want %h hit %b", n, csr_addr, csr_rdata, csr_hit, exp_d, exp_hit); end
            cyc();
            n_tests++; if (redirect_valid !== m_busy || busy !== m_busy || redirect_pc !== m_rpc) begin
                n_fail++; $display("FAIL rand_redirect_%0d: got valid %b busy %b pc %h want %b %b %h", n, redirect_valid, busy, redirect_pc, m_busy, m_busy, m_rpc); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_trap();
        test_priority();
        test_stall_and_mret();
        test_csr_drop();
        test_vectored();
        test_reset_mid_redirect();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
